// File: rtl/ahb_extmem_sram_if.sv
// +--------------------------------------------------------------------------+
// | Module   : ahb_extmem_sram_if                                            |
// | Brief    : AHB-Lite bus bundle between the SoC external port and memory  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ahb_extmem_sram_if #(
  parameter int PA_BITS = 56,
  parameter int AHBW    = 64
);
  logic                HSELEXT;
  logic [PA_BITS-1:0]  HADDR;
  logic                HWRITE;
  logic [1:0]          HTRANS;
  logic [2:0]          HSIZE;
  logic [2:0]          HBURST;
  logic                HREADY;
  logic [AHBW-1:0]     HWDATA;
  logic [AHBW/8-1:0]   HWSTRB;
  logic [AHBW-1:0]     HRDATAEXT;
  logic                HREADYEXT;
  logic                HRESPEXT;

  modport master (
    output HSELEXT, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HREADY, HWDATA, HWSTRB,
    input  HRDATAEXT, HREADYEXT, HRESPEXT
  );

  modport slave (
    input  HSELEXT, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HREADY, HWDATA, HWSTRB,
    output HRDATAEXT, HREADYEXT, HRESPEXT
  );
endinterface

`default_nettype wire

// File: rtl/ahb_extmem_sram.sv
// +--------------------------------------------------------------------------+
// | Module   : ahb_extmem_sram                                               |
// | Brief    : AHB-Lite external-memory model: word array, wait states and   |
// |            store-to-load forwarding. EXTMEM_ERRRESP_EN enables the       |
// |            out-of-range ERROR response.                                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module ahb_extmem_sram #(
  parameter int                 PA_BITS     = 56,
  parameter int                 AHBW        = 64,
  parameter logic [PA_BITS-1:0] BASE        = 'h8000_0000,
  parameter int                 DEPTH       = 4096,
  parameter int                 WAIT_STATES = 0
) (
  input  wire logic            HCLK,
  input  wire logic            HRESETn,
  ahb_extmem_sram_if.slave     bus
);

  localparam int         c_bytes   = AHBW / 8;
  localparam int         c_bw      = $clog2(c_bytes);
  localparam int         c_aw      = $clog2(DEPTH);
  localparam logic [3:0] c_ws_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_resp;
  logic [AHBW-1:0]   r_rdata;
  logic [AHBW-1:0]   r_rbuf;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [c_aw-1:0]   r_idx;
  logic [AHBW-1:0]   r_mem [DEPTH];

  logic              w_accept;
  logic [PA_BITS-1:0] w_off;
  logic [c_aw-1:0]   w_idx;
  logic              w_oor;
  logic              w_commit;
  logic [AHBW-1:0]   w_cur;
  logic [AHBW-1:0]   w_merged;
  logic [AHBW-1:0]   w_rd_word;
  logic              w_unused_ok;

  assign w_accept = bus.HSELEXT & bus.HREADY & bus.HTRANS[1];
  assign w_off    = bus.HADDR - BASE;
  assign w_idx    = w_off[c_aw+c_bw-1:c_bw];

`ifdef EXTMEM_ERRRESP_EN
  assign w_oor = (bus.HADDR < BASE) | (|(w_off >> (c_aw + c_bw)));
`else
  assign w_oor = 1'b0;
`endif

  assign w_unused_ok = ^{bus.HSIZE, bus.HBURST, bus.HTRANS, w_off};

  // The write of the data phase ending at this edge; a read accepted on the
  // same edge must see its lanes.
  assign w_commit = (r_state == S_DATA) & r_write;
  assign w_cur    = r_mem[r_idx];

  for (genvar i = 0; i < c_bytes; i++) begin : g_lane
    assign w_merged[8*i +: 8] = bus.HWSTRB[i] ? bus.HWDATA[8*i +: 8] : w_cur[8*i +: 8];
  end

  assign w_rd_word = (w_commit && (r_idx == w_idx)) ? w_merged : r_mem[w_idx];

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      r_mem[r_idx] <= w_merged;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_resp  <= 1'b0;
      r_rdata <= '0;
      r_rbuf  <= '0;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DATA;
            r_ready <= 1'b1;
            if (!r_write) begin
              r_rdata <= r_rbuf;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`ifdef EXTMEM_ERRRESP_EN
        S_ERR1: begin
          r_state <= S_ERR2;
          r_ready <= 1'b1;
          r_resp  <= 1'b1;
        end
`endif
        default: begin
          // IDLE, DATA and ERR2 all complete on this edge and may accept.
          if (w_accept) begin
            r_write <= bus.HWRITE;
            r_idx   <= w_idx;
            if (w_oor) begin
              r_state <= S_ERR1;
              r_ready <= 1'b0;
              r_resp  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_ready <= 1'b0;
              r_resp  <= 1'b0;
              r_cnt   <= c_ws_load;
              if (!bus.HWRITE) begin
                r_rbuf <= w_rd_word;
              end
            end else begin
              r_state <= S_DATA;
              r_ready <= 1'b1;
              r_resp  <= 1'b0;
              if (!bus.HWRITE) begin
                r_rdata <= w_rd_word;
              end
            end
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_resp  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.HRDATAEXT = r_rdata;
  assign bus.HREADYEXT = r_ready;
  assign bus.HRESPEXT  = r_resp;

endmodule

`default_nettype wire
